nbit_serial_subtractor: RTL
===========================

# nbit_serial_subtractor

Multi-cycle WIDTH-bit two's-complement subtractor that computes D = X − Y − initBin one SLICE-bit chunk per clock, LSB slice first, rippling the borrow between slices through a register. It is the subtract-side counterpart of the combinational n-bit carry-lookahead adder datapath. It trades latency for a short critical path: one SLICE-bit lookahead stage per cycle. It sits behind a valid/ready handshake on both sides so it can drop into the ALU pipeline.

## Interface
- WIDTH, 64, operand and result width; must be a positive multiple of SLICE.
- SLICE, 8, bits processed per cycle; NSLICE = WIDTH/SLICE.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- X  input  WIDTH  minuend.
- Y  input  WIDTH  subtrahend.
- initBin  input  1  borrow-in.
- out_valid  output  1  result registered and stable.
- out_ready  input  1  consumer takes result.
- D  output  WIDTH  difference, registered.
- Bout  output  1  borrow-out (unsigned X < Y + initBin).
- Ovf  output  1  signed overflow.

## Operation
- Subtraction is addition: slice k computes X[k] + ~Y[k] + c. The carry register c starts at ~initBin. Bout = ~c after the final slice.
- The FSM has three states: IDLE, BUSY and DONE.
- IDLE:
  - in_ready = 1.
  - on in_valid: latch X, Y and c = ~initBin; clear the slice index to 0; go to BUSY.
- BUSY:
  - in_ready = 0 and out_valid = 0.
  - Each cycle, write slice k of the result register, update c, and increment k.
  - After slice NSLICE−1 is written, go to DONE.
- DONE:
  - out_valid = 1; D, Bout and Ovf are held stable.
  - Ovf = (X[WIDTH−1] ≠ Y[WIDTH−1]) & (D[WIDTH−1] ≠ X[WIDTH−1]).
  - On out_ready, go to IDLE.
- Inputs are ignored outside IDLE; no second operation overlaps.
- The operand registers are captured once. Changes on X/Y after acceptance have no effect.
- The result register is written slice by slice. D is only meaningful while out_valid = 1.

## Timing
- Reset values (asynchronous, while rst_n = 0):
  - state = IDLE, so in_ready = 1.
  - out_valid = 0, D = 0, Bout = 0, Ovf = 0.
  - slice index = 0, c = 0.
- Acceptance happens at edge t, when in_valid & in_ready.
- Slices 0..NSLICE−1 are written at edges t+1..t+NSLICE.
- out_valid rises after edge t+NSLICE. Latency is NSLICE cycles (8 with defaults).
- Consumer handshake:
  - out_ready sampled high with out_valid high at edge u → out_valid = 0 and in_ready = 1 after edge u.
  - The next acceptance is possible at edge u+1.
  - Minimum issue interval is NSLICE+2 cycles.
- out_ready asserted outside DONE has no effect.
- Reset mid-BUSY or mid-DONE aborts the operation immediately. There is no partial out_valid pulse and no resumed state.
- in_ready and out_valid decode from state only. There is no combinational path from any input to any output.

## Structure
- The shared package/header holds:
  - the FSM state encoding (IDLE, BUSY, DONE);
  - NSLICE;
  - a slice-index width constant, clog2(NSLICE) with a minimum of 1.
- Sub-module cla_slice: a combinational SLICE-bit carry-lookahead adder with ports a, b, cin, sum, cout. It is built from generate = a&b and propagate = a^b per bit.
  - The top instantiates cla_slice once, fed with ~Y.
  - Slice selection is done by indexed part-select on the operand registers.
- The top holds the FSM, operand registers, carry register, result register and handshake.

## Test plan
- X=0x0000_0001_0000_0000, Y=1, initBin=0 → D=0x0000_0000_FFFF_FFFF, Bout=0, Ovf=0, out_valid exactly 8 cycles after acceptance; checks cross-slice borrow.
- X=0, Y=1, initBin=0 → D=0xFFFF_FFFF_FFFF_FFFF, Bout=1, Ovf=0.
- X=0x8000_0000_0000_0000, Y=1, initBin=0 → D=0x7FFF_FFFF_FFFF_FFFF, Bout=0, Ovf=1.
- X=5, Y=5, initBin=1 → D=0xFFFF_FFFF_FFFF_FFFF, Bout=1, Ovf=0.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles in DONE, pulsing in_valid with new operands.
  - Required: D, Bout and Ovf stable; in_ready=0; new operands ignored.
  - After the out_ready pulse: in_ready=1 the next cycle, and the following op returns the correct result.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 during BUSY after slice 3.
  - Required: out_valid=0, in_ready=1, D=0 immediately.
  - After release: X=100, Y=58 → D=42, Bout=0.

Source files
------------

// File: rtl/nbit_serial_subtractor_pkg.sv
// Shared definitions for the slice-serial subtractor: FSM encoding, default slice count
// and the index-width helper.
package nbit_serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_SLICE = 8;
  localparam int NSLICE    = DEF_WIDTH / DEF_SLICE;

  // clog2 with a floor of one bit so a single-slice build still has an index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W = idx_width(NSLICE);

endpackage

// File: rtl/nbit_serial_subtractor_cla_slice.sv
// Combinational W-bit carry-lookahead adder built from per-bit generate/propagate terms.
module cla_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   carry;

  assign g        = a & b;
  assign p        = a ^ b;
  assign carry[0] = cin;

  // Each carry is the flat OR of every generate term propagated up to it, not a ripple chain.
  for (genvar gi = 0; gi < W; gi++) begin : g_carry
    logic cc;
    logic pp;
    always_comb begin
      cc = g[gi];
      pp = p[gi];
      for (int j = gi - 1; j >= 0; j--) begin
        cc = cc | (pp & g[j]);
        pp = pp & p[j];
      end
      cc = cc | (pp & cin);
    end
    assign carry[gi+1] = cc;
  end

  assign sum  = p ^ carry[W-1:0];
  assign cout = carry[W];

endmodule

// File: rtl/nbit_serial_subtractor.sv
// WIDTH-bit subtractor D = X - Y - initBin, one SLICE-bit lookahead stage per clock,
// LSB slice first, with valid/ready handshakes on both sides.
module nbit_serial_subtractor
  import nbit_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             initBin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             Ovf
);

  localparam int NS = WIDTH / SLICE;
  localparam int KW = idx_width(NS);
  localparam int BW = idx_width(WIDTH);
  localparam logic [KW-1:0] K_LAST = KW'(NS - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  x_q, y_q, d_q;
  logic              c_q, bout_q, ovf_q;
  logic [KW-1:0]     k_q;
  logic [BW-1:0]     base;
  logic [SLICE-1:0]  slice_sum;
  logic              slice_cout;
  logic              accept, last_slice;

  assign accept     = (state_q == ST_IDLE) && in_valid;
  assign last_slice = (k_q == K_LAST);
  assign base       = BW'(k_q) * BW'(SLICE);

  // Subtraction as X + ~Y + c, where c enters as the inverted borrow.
  cla_slice #(.W(SLICE)) u_cla (
    .a    (x_q[base +: SLICE]),
    .b    (~y_q[base +: SLICE]),
    .cin  (c_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)   state_d = ST_BUSY;
      ST_BUSY: if (last_slice) state_d = ST_DONE;
      ST_DONE: if (out_ready)  state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      d_q    <= '0;
      c_q    <= 1'b0;
      k_q    <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      x_q <= X;
      y_q <= Y;
      c_q <= ~initBin;
      k_q <= '0;
    end else if (state_q == ST_BUSY) begin
      d_q[base +: SLICE] <= slice_sum;
      c_q                <= slice_cout;
      k_q                <= last_slice ? '0 : k_q + 1'b1;
      if (last_slice) begin
        bout_q <= ~slice_cout;
        ovf_q  <= (x_q[WIDTH-1] ^ y_q[WIDTH-1]) & (slice_sum[SLICE-1] ^ x_q[WIDTH-1]);
      end
    end
  end

  assign D    = d_q;
  assign Bout = bout_q;
  assign Ovf  = ovf_q;

endmodule
